// File: rtl/water_tank_sensor_model.sv
// Supply-tank model: integrates pump/drain commands into a saturating level and
// drives debounced low/mid/high level-sensor lines with stuck-at-1 fault injection.
module water_tank_sensor_model #(
  parameter int unsigned LEVEL_WIDTH   = 8,
  parameter int unsigned CAPACITY      = 200,
  parameter int unsigned LOW_MARK      = 20,
  parameter int unsigned MID_MARK      = 100,
  parameter int unsigned HIGH_MARK     = 180,
  parameter int unsigned FILL_RATE     = 2,
  parameter int unsigned DRAIN_RATE    = 1,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   pump_on_i,
  input  logic                   drain_on_i,
  input  logic [2:0]             fault_stuck_i,
  output logic                   low_level_o,
  output logic                   mid_level_o,
  output logic                   high_level_o,
  output logic [LEVEL_WIDTH-1:0] water_level_o,
  output logic [2:0]             tank_state_o,
  output logic                   overflow_o,
  output logic                   dry_run_o
);

  if (!(LOW_MARK > 0 && LOW_MARK < MID_MARK && MID_MARK < HIGH_MARK &&
        HIGH_MARK <= CAPACITY && 64'(CAPACITY) < (64'(1) << LEVEL_WIDTH) &&
        SETTLE_CYCLES >= 1 && SETTLE_CYCLES <= 15)) begin : g_bad_cfg
    $error("water_tank_sensor_model: illegal parameter configuration");
  end

  typedef enum logic [2:0] {
    StEmpty    = 3'd0,
    StFilling  = 3'd1,
    StDraining = 3'd2,
    StSteady   = 3'd3,
    StFull     = 3'd4
  } tank_state_e;

  localparam int unsigned SumW = LEVEL_WIDTH + 2;
  localparam logic [LEVEL_WIDTH-1:0] CapL  = LEVEL_WIDTH'(CAPACITY);
  localparam logic [LEVEL_WIDTH-1:0] LowL  = LEVEL_WIDTH'(LOW_MARK);
  localparam logic [LEVEL_WIDTH-1:0] MidL  = LEVEL_WIDTH'(MID_MARK);
  localparam logic [LEVEL_WIDTH-1:0] HighL = LEVEL_WIDTH'(HIGH_MARK);
  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);
  // Simultaneous pump+drain cancels a saturation flag only if the opposing rate wins or ties.
  localparam bit DrainBeatsFill = (DRAIN_RATE >= FILL_RATE);
  localparam bit FillBeatsDrain = (FILL_RATE >= DRAIN_RATE);

  logic [LEVEL_WIDTH-1:0] level_q, level_d;
  logic [SumW-1:0]        sum_s;
  logic [2:0]             raw;
  logic [2:0]             settled_q, settled_d;
  logic [2:0][3:0]        cnt_q, cnt_d;
  logic [2:0]             out_q, out_d;
  tank_state_e            state_q, state_d;
  logic                   overflow_q, overflow_d;
  logic                   dry_run_q, dry_run_d;

  // Net level delta in two's complement with guard bits, then clamp to [0, CAPACITY].
  always_comb begin
    sum_s = {2'b00, level_q};
    if (pump_on_i)  sum_s = sum_s + SumW'(FILL_RATE);
    if (drain_on_i) sum_s = sum_s - SumW'(DRAIN_RATE);
    if (sum_s[SumW-1])                 level_d = '0;   // went negative
    else if (sum_s > SumW'(CAPACITY))  level_d = CapL;
    else                               level_d = sum_s[LEVEL_WIDTH-1:0];
  end

  assign raw = {level_q >= HighL, level_q >= MidL, level_q >= LowL};

  // Per-sensor debounce: flip only after SETTLE_CYCLES consecutive disagreeing edges.
  always_comb begin
    settled_d = settled_q;
    cnt_d     = cnt_q;
    for (int k = 0; k < 3; k++) begin
      if (raw[k] == settled_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == SettleLast) begin
        settled_d[k] = raw[k];
        cnt_d[k]     = '0;
      end else begin
        cnt_d[k] = cnt_q[k] + 4'd1;
      end
    end
    // Faults only mask the line; the debounce state underneath is untouched.
    out_d = settled_d | fault_stuck_i;
  end

  // Tank state and per-cycle status flags from the upcoming level.
  always_comb begin
    state_d = StSteady;
    if (level_d == '0)          state_d = StEmpty;
    else if (level_d == CapL)   state_d = StFull;
    else if (level_d > level_q) state_d = StFilling;
    else if (level_d < level_q) state_d = StDraining;
    overflow_d = pump_on_i && (level_q == CapL) && !(drain_on_i && DrainBeatsFill);
    dry_run_d  = drain_on_i && (level_q == '0) && !(pump_on_i && FillBeatsDrain);
  end

  // State registers; asynchronous reset clears everything including partial settle counts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q    <= '0;
      settled_q  <= '0;
      cnt_q      <= '0;
      out_q      <= '0;
      state_q    <= StEmpty;
      overflow_q <= 1'b0;
      dry_run_q  <= 1'b0;
    end else begin
      level_q    <= level_d;
      settled_q  <= settled_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      state_q    <= state_d;
      overflow_q <= overflow_d;
      dry_run_q  <= dry_run_d;
    end
  end

  assign low_level_o   = out_q[0];
  assign mid_level_o   = out_q[1];
  assign high_level_o  = out_q[2];
  assign water_level_o = level_q;
  assign tank_state_o  = state_q;
  assign overflow_o    = overflow_q;
  assign dry_run_o     = dry_run_q;

endmodule

// File: tb/tb_water_tank_sensor_model.sv
// Self-checking bench: directed scenarios plus randomized pump/drain/fault/reset
// traffic, all compared against an integer reference model of the tank.
module tb_water_tank_sensor_model;

  localparam int Cap    = 200;
  localparam int Fill   = 2;
  localparam int Drain  = 1;
  localparam int Settle = 4;
  localparam int Empty = 0, Filling = 1, Draining = 2, Steady = 3, Full = 4;

  int marks[3] = '{20, 100, 180};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pump = 1'b0;
  logic       drain = 1'b0;
  logic [2:0] fault = 3'b000;
  logic       low_l, mid_l, high_l, ovf, dry;
  logic [7:0] level;
  logic [2:0] state;

  water_tank_sensor_model dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .pump_on_i     (pump),
    .drain_on_i    (drain),
    .fault_stuck_i (fault),
    .low_level_o   (low_l),
    .mid_level_o   (mid_l),
    .high_level_o  (high_l),
    .water_level_o (level),
    .tank_state_o  (state),
    .overflow_o    (ovf),
    .dry_run_o     (dry)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  string phase = "init";

  // Reference model: tank level, a disagreement run length per sensor, and what each line shows.
  int m_lvl;
  int m_set[3];
  int m_run[3];
  int m_out[3];
  int m_state, m_ov, m_dr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s/%s: got %0d expected %0d", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lvl = 0; m_state = Empty; m_ov = 0; m_dr = 0;
    for (int k = 0; k < 3; k++) begin
      m_set[k] = 0; m_run[k] = 0; m_out[k] = 0;
    end
  endtask

  task automatic model_edge(input bit p, input bit d, input logic [2:0] f);
    int nl;
    nl = m_lvl + (p ? Fill : 0) - (d ? Drain : 0);
    if (nl < 0) nl = 0;
    if (nl > Cap) nl = Cap;
    for (int k = 0; k < 3; k++) begin
      int wet;
      wet = (m_lvl >= marks[k]) ? 1 : 0;
      if (wet == m_set[k]) m_run[k] = 0;
      else begin
        m_run[k]++;
        if (m_run[k] == Settle) begin
          m_set[k] = wet;
          m_run[k] = 0;
        end
      end
      m_out[k] = m_set[k] | int'(f[k]);
    end
    if (nl == 0)          m_state = Empty;
    else if (nl == Cap)   m_state = Full;
    else if (nl > m_lvl)  m_state = Filling;
    else if (nl < m_lvl)  m_state = Draining;
    else                  m_state = Steady;
    m_ov = (p && m_lvl == Cap && !(d && Drain >= Fill)) ? 1 : 0;
    m_dr = (d && m_lvl == 0 && !(p && Fill >= Drain)) ? 1 : 0;
    m_lvl = nl;
  endtask

  task automatic check_all();
    check_eq("level", 32'(level), m_lvl);
    check_eq("low", 32'(low_l), m_out[0]);
    check_eq("mid", 32'(mid_l), m_out[1]);
    check_eq("high", 32'(high_l), m_out[2]);
    check_eq("state", 32'(state), m_state);
    check_eq("overflow", 32'(ovf), m_ov);
    check_eq("dry_run", 32'(dry), m_dr);
  endtask

  task automatic check_zero();
    check_eq("rst_level", 32'(level), 0);
    check_eq("rst_sensors", 32'({high_l, mid_l, low_l}), 0);
    check_eq("rst_state", 32'(state), Empty);
    check_eq("rst_flags", 32'({ovf, dry}), 0);
  endtask

  // One clock edge with the given inputs, then compare every output against the model.
  task automatic step(input bit p, input bit d, input logic [2:0] f);
    @(negedge clk);
    pump = p; drain = d; fault = f;
    @(posedge clk);
    model_edge(p, d, f);
    #1 check_all();
  endtask

  // Asynchronous pulse between edges; outputs must clear before any clock edge arrives.
  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero();
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int pp, pd;
    logic [2:0] f;
    model_reset();
    #1 rst_n = 1'b0;
    #2 phase = "reset";
    check_zero();
    repeat (2) @(posedge clk);
    #1 check_zero();
    #1 rst_n = 1'b1;

    // Constant fill to saturation.
    phase = "fill";
    for (int n = 1; n <= 100; n++) begin
      step(1'b1, 1'b0, 3'b000);
      if (n == 1)  check_eq("state_e1", 32'(state), Filling);
      if (n == 10) check_eq("level_e10", 32'(level), 20);
      if (n == 13) check_eq("low_e13", 32'(low_l), 0);
      if (n == 14) check_eq("low_e14", 32'(low_l), 1);
      if (n == 93) check_eq("high_e93", 32'(high_l), 0);
      if (n == 94) check_eq("high_e94", 32'(high_l), 1);
    end
    check_eq("level_e100", 32'(level), 200);
    check_eq("state_full", 32'(state), Full);
    step(1'b1, 1'b0, 3'b000);
    check_eq("overflow_e101", 32'(ovf), 1);
    step(1'b1, 1'b1, 3'b000);
    check_eq("overflow_net", 32'(ovf), 1);

    // Simultaneous pump and drain, then drain to empty.
    phase = "net";
    do_reset();
    repeat (25) step(1'b1, 1'b0, 3'b000);
    check_eq("level_50", 32'(level), 50);
    repeat (10) step(1'b1, 1'b1, 3'b000);
    check_eq("level_60", 32'(level), 60);
    check_eq("state_netfill", 32'(state), Filling);
    step(1'b0, 1'b1, 3'b000);
    check_eq("state_drain", 32'(state), Draining);
    repeat (59) step(1'b0, 1'b1, 3'b000);
    check_eq("state_empty", 32'(state), Empty);
    step(1'b0, 1'b1, 3'b000);
    check_eq("dry_run", 32'(dry), 1);

    // Debounce around the mid mark.
    phase = "debounce";
    do_reset();
    repeat (49) step(1'b1, 1'b0, 3'b000);
    step(1'b1, 1'b1, 3'b000);
    repeat (6) step(1'b0, 1'b0, 3'b000);
    check_eq("level_99", 32'(level), 99);
    step(1'b1, 1'b0, 3'b000);
    step(1'b0, 1'b1, 3'b000);
    step(1'b0, 1'b1, 3'b000);
    step(1'b0, 1'b0, 3'b000);
    check_eq("mid_glitch", 32'(mid_l), 0);
    step(1'b1, 1'b1, 3'b000);
    repeat (3) step(1'b0, 1'b0, 3'b000);
    check_eq("mid_3rd", 32'(mid_l), 0);
    step(1'b0, 1'b0, 3'b000);
    check_eq("mid_4th", 32'(mid_l), 1);

    // Stuck-at-1 fault on the high sensor at an empty tank.
    phase = "fault";
    do_reset();
    step(1'b0, 1'b0, 3'b100);
    check_eq("fault_pattern", 32'({high_l, mid_l, low_l}), 3'b100);
    step(1'b0, 1'b0, 3'b000);
    check_eq("fault_clear", 32'(high_l), 0);

    // Reset in the middle of a fill, then the low sensor must settle from scratch.
    phase = "midreset";
    do_reset();
    repeat (75) step(1'b1, 1'b0, 3'b000);
    check_eq("mid_at150", 32'(mid_l), 1);
    do_reset();
    for (int n = 1; n <= 14; n++) begin
      step(1'b1, 1'b0, 3'b000);
      if (n == 13) check_eq("refill_low13", 32'(low_l), 0);
      if (n == 14) check_eq("refill_low14", 32'(low_l), 1);
    end

    // Randomized traffic in segments with varying pump/drain bias.
    phase = "random";
    do_reset();
    f = 3'b000;
    pp = 50; pd = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) begin
        pp = $urandom_range(10, 90);
        pd = $urandom_range(10, 90);
      end
      if ($urandom_range(0, 99) < 4) f = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 399) == 0) do_reset();
      step($urandom_range(0, 99) < pp, $urandom_range(0, 99) < pd, f);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/water_tank_sensor_model.md
Name: water_tank_sensor_model

Overview:
- Cycle-based model of the supply tank. It integrates pump and drain commands into a water level.
- Drives the three level-sensor lines (low/mid/high) with sensor settling delay.
- Supports per-sensor stuck-at-1 fault injection, so the conflict-detection path sees both legal and conflicting sensor patterns.
- Sits on the sensor side of the water-supply subsystem: the source end of the sensor interface, for simulation benches and FPGA demo builds.

Parameters:
- LEVEL_WIDTH, 8, width of water_level.
- CAPACITY, 200, maximum level (saturation point).
- LOW_MARK, 20, level at or above which the low sensor is wet.
- MID_MARK, 100, mid sensor threshold.
- HIGH_MARK, 180, high sensor threshold.
- FILL_RATE, 2, level units added per cycle with pump_on.
- DRAIN_RATE, 1, level units removed per cycle with drain_on.
- SETTLE_CYCLES, 4, consecutive disagreeing cycles before a sensor output flips (range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pump_on  input  1  inflow enabled this cycle.
- drain_on  input  1  outflow enabled this cycle.
- fault_stuck  input  3  per-sensor stuck-at-1 force: bit0 low, bit1 mid, bit2 high.
- low_level  output  1  low sensor line.
- mid_level  output  1  mid sensor line.
- high_level  output  1  high sensor line.
- water_level  output  LEVEL_WIDTH  current modelled level.
- tank_state  output  3  0 EMPTY, 1 FILLING, 2 DRAINING, 3 STEADY, 4 FULL.
- overflow  output  1  pump_on while level already at CAPACITY.
- dry_run  output  1  drain_on while level already 0.

Behaviour:
Reset (rst_n low, asynchronous):
- water_level=0, all sensor outputs 0, settle counters 0, tank_state=EMPTY, overflow=0, dry_run=0.
- Release is synchronous to clk; the first update occurs on the first rising edge with rst_n high.

Level update, every edge:
- next = level + (pump_on ? FILL_RATE : 0) - (drain_on ? DRAIN_RATE : 0).
- Compute with 2 extra guard bits (signed), then saturate to [0, CAPACITY].
- pump_on and drain_on together give the net delta; they are not mutually exclusive.

Sensor path (each sensor k, independent):
- raw_k = (registered level >= MARK_k).
- settled_k register with counter cnt_k:
  - If raw_k == settled_k at an edge: cnt_k <= 0.
  - Else cnt_k increments. On the SETTLE_CYCLES-th consecutive disagreeing edge, settled_k <= raw_k and cnt_k <= 0.
- A level that crosses back before settling resets the count; this is the debounce.
- Output register: out_k <= next settled_k OR fault_stuck[k].
  - Fault assertion/deassertion is visible one edge later.
  - A fault does not disturb settled_k or cnt_k.
- With no faults, outputs are always thermometer-coded (high implies mid implies low), because MARKs are strictly ordered.

tank_state, registered from next level vs current level:
- next == 0 -> EMPTY.
- next == CAPACITY -> FULL.
- next > level -> FILLING.
- next < level -> DRAINING.
- Otherwise STEADY.
- EMPTY and FULL take priority.

Status flags, registered per cycle (not sticky):
- overflow <= pump_on && level == CAPACITY && !(drain_on && DRAIN_RATE >= FILL_RATE).
- dry_run <= drain_on && level == 0 && !(pump_on && FILL_RATE >= DRAIN_RATE).

Legal configuration:
- 0 < LOW_MARK < MID_MARK < HIGH_MARK <= CAPACITY < 2^LEVEL_WIDTH.
- Violations are flagged by an elaboration-time check; behaviour is otherwise undefined.

Reset mid-operation:
- Immediately clears all state, including partially counted settle counters.
- No sensor output may glitch high during reset.

Test Plan:
- Reset then pump_on=1 constant (defaults): water_level=2·n after edge n. Level reaches 20 at edge 10. low_level=1 after edge 14, not before. mid_level=0 until the level has been at or above 100 for 4 edges. tank_state=FILLING from edge 1.
- Keep pumping to saturation: water_level holds 200 from edge 100. tank_state=FULL. high_level=1 by edge 94 (level 180 reached at edge 90, flips on edge 94). overflow=1 from edge 101 while pump_on.
- pump_on and drain_on both high at level 50: level rises by 1 per edge, tank_state=FILLING. Then drain only: falls by 1 per edge, DRAINING. At 0 with drain_on: EMPTY and dry_run=1.
- Debounce: hold level at 99 until settled, then alternate pump/drain so the level toggles 99/101/100/99 within 3 edges. mid_level must stay 0. Hold at or above 100 for 4 edges: mid_level rises exactly on the 4th.
- Fault injection at level 0: set fault_stuck=3'b100 -> high_level=1 one edge later, low/mid=0 (conflict pattern). Clear the fault -> high_level=0 next edge, settle counters unaffected.
- Assert rst_n=0 mid-fill at level 150 with mid_level=1: all outputs are 0 immediately (asynchronously). After release, refilling re-honours the full 4-edge settle on low_level.
